// File: rtl/version_responder.sv
// Build identity constants and the byte-stream responder that reports them.
// Answers a version query with a 14-byte framed record and a ping with a 3-byte frame.

package version_pkg;
  localparam logic [7:0]  MAJOR  = 8'h00;
  localparam logic [7:0]  MINOR  = 8'h00;
  localparam logic [7:0]  PATCH  = 8'h00;
  localparam logic [7:0]  BUILD  = 8'h36;
  localparam logic [15:0] YEAR   = 16'h2025;
  localparam logic [7:0]  MONTH  = 8'h11;
  localparam logic [7:0]  DAY    = 8'h05;
  localparam logic [7:0]  HOUR   = 8'h18;
  localparam logic [7:0]  MINUTE = 8'h54;
  localparam logic [7:0]  SECOND = 8'h41;
endpackage

module version_responder #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter logic [7:0] CMD_VERSION = 8'h56,
  parameter logic [7:0] CMD_PING    = 8'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       req_dropped
);
  import version_pkg::*;

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state_q, state_d;
  logic       is_ping_q, is_ping_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       pend_valid_q, pend_valid_d;
  logic       pend_ping_q, pend_ping_d;
  logic       drop_q, drop_d;

  logic       cmd_hit;
  logic       cmd_is_ping;
  logic       hs;
  logic [3:0] last_idx;
  logic [3:0] nxt_idx;
  logic [7:0] chk_next;

  // Payload bytes by index; the checksum byte is supplied from the accumulator instead.
  function automatic logic [7:0] byte_at(input logic ping, input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (ping) begin
      if (idx == 4'd1) b = CMD_PING;
    end else begin
      case (idx)
        4'd1:    b = CMD_VERSION;
        4'd2:    b = MAJOR;
        4'd3:    b = MINOR;
        4'd4:    b = PATCH;
        4'd5:    b = BUILD;
        4'd6:    b = YEAR[15:8];
        4'd7:    b = YEAR[7:0];
        4'd8:    b = MONTH;
        4'd9:    b = DAY;
        4'd10:   b = HOUR;
        4'd11:   b = MINUTE;
        4'd12:   b = SECOND;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  always_comb begin
    state_d      = state_q;
    is_ping_d    = is_ping_q;
    idx_d        = idx_q;
    chk_d        = chk_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    pend_valid_d = pend_valid_q;
    pend_ping_d  = pend_ping_q;
    drop_d       = drop_q;

    cmd_is_ping = (rx_data == CMD_PING);
    cmd_hit     = rx_valid && ((rx_data == CMD_VERSION) || cmd_is_ping);
    hs          = (state_q == SEND) && tx_valid_q && tx_ready;
    last_idx    = is_ping_q ? 4'd2 : 4'd13;
    nxt_idx     = idx_q + 4'd1;
    // The header (index 0) is excluded from the checksum.
    chk_next    = (idx_q != 4'd0) ? (chk_q ^ tx_data_q) : chk_q;

    case (state_q)
      IDLE: begin
        if (cmd_hit) begin
          state_d    = SEND;
          is_ping_d  = cmd_is_ping;
          idx_d      = 4'd0;
          chk_d      = 8'h00;
          tx_data_d  = HEADER;
          tx_valid_d = 1'b1;
        end
      end
      SEND: begin
        if (hs && (idx_q == last_idx)) begin
          if (pend_valid_q) begin
            is_ping_d    = pend_ping_q;
            idx_d        = 4'd0;
            chk_d        = 8'h00;
            tx_data_d    = HEADER;
            pend_valid_d = cmd_hit;
            pend_ping_d  = cmd_is_ping;
          end else if (cmd_hit) begin
            // A command colliding with the final handshake starts without a gap.
            is_ping_d = cmd_is_ping;
            idx_d     = 4'd0;
            chk_d     = 8'h00;
            tx_data_d = HEADER;
          end else begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            idx_d      = 4'd0;
          end
        end else begin
          if (hs) begin
            idx_d     = nxt_idx;
            chk_d     = chk_next;
            tx_data_d = (nxt_idx == last_idx) ? chk_next : byte_at(is_ping_q, nxt_idx);
          end
          if (cmd_hit) begin
            if (pend_valid_q) begin
              drop_d = 1'b1;
            end else begin
              pend_valid_d = 1'b1;
              pend_ping_d  = cmd_is_ping;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      is_ping_q    <= 1'b0;
      idx_q        <= 4'd0;
      chk_q        <= 8'h00;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_ping_q  <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_ping_q    <= is_ping_d;
      idx_q        <= idx_d;
      chk_q        <= chk_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      pend_valid_q <= pend_valid_d;
      pend_ping_q  <= pend_ping_d;
      drop_q       <= drop_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = (state_q == SEND) | pend_valid_q;
  assign req_dropped = drop_q;

endmodule

// File: tb/tb_version_responder.sv
// Directed bench for version_responder: frame contents, backpressure, queueing,
// overflow, end-of-frame collision and mid-frame reset.

module tb_version_responder;
  import version_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       req_dropped;

  int n_checks;
  int n_fail;

  logic [7:0] exp_ver [14];
  logic [7:0] exp_ping [3];

  version_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .req_dropped (req_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] cmd);
    rx_data  = cmd;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Walks one frame with tx_ready high; optionally strobes a command on byte inj_at's handshake.
  task automatic expect_frame(input string name, input logic is_ping,
                              input int inj_at, input logic [7:0] inj_cmd);
    int len;
    len = is_ping ? 3 : 14;
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s_valid[%0d]", name, i), {7'd0, tx_valid}, 8'd1);
      check($sformatf("%s_byte[%0d]", name, i), tx_data, is_ping ? exp_ping[i] : exp_ver[i]);
      if (i == inj_at) begin
        rx_data  = inj_cmd;
        rx_valid = 1'b1;
      end
      tick();
      rx_valid = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] acc;
    n_checks = 0;
    n_fail   = 0;

    exp_ver[0]  = 8'hA5;       exp_ver[1]  = 8'h56;
    exp_ver[2]  = MAJOR;       exp_ver[3]  = MINOR;
    exp_ver[4]  = PATCH;       exp_ver[5]  = BUILD;
    exp_ver[6]  = YEAR[15:8];  exp_ver[7]  = YEAR[7:0];
    exp_ver[8]  = MONTH;       exp_ver[9]  = DAY;
    exp_ver[10] = HOUR;        exp_ver[11] = MINUTE;
    exp_ver[12] = SECOND;
    acc = 8'h00;
    for (int i = 1; i < 13; i++) acc = acc ^ exp_ver[i];
    exp_ver[13] = acc;
    exp_ping[0] = 8'hA5; exp_ping[1] = 8'h50; exp_ping[2] = 8'h50;

    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    tick(); tick();
    check("rst_tx_valid", {7'd0, tx_valid}, 8'd0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_dropped", {7'd0, req_dropped}, 8'd0);
    rst_n = 1'b1;
    tick();

    // Version query, ready held high.
    strobe(8'h56);
    expect_frame("ver", 1'b0, -1, 8'h00);
    check("ver_end_valid", {7'd0, tx_valid}, 8'd0);
    check("ver_end_busy", {7'd0, busy}, 8'd0);

    // Ping with tx_ready 1-0-0-1.
    strobe(8'h50);
    check("ping_b0", tx_data, 8'hA5);
    tx_ready = 1'b1; tick();
    check("ping_b1", tx_data, 8'h50);
    tx_ready = 1'b0; tick();
    check("ping_stall1", tx_data, 8'h50);
    check("ping_stall1_valid", {7'd0, tx_valid}, 8'd1);
    tick();
    check("ping_stall2", tx_data, 8'h50);
    tx_ready = 1'b1; tick();
    check("ping_chk", tx_data, 8'h50);
    check("ping_chk_valid", {7'd0, tx_valid}, 8'd1);
    tick();
    check("ping_end_valid", {7'd0, tx_valid}, 8'd0);

    // Non-commands are ignored; a ping queued during a version frame follows without a gap.
    strobe(8'h00);
    strobe(8'h41);
    tick();
    check("ign_valid", {7'd0, tx_valid}, 8'd0);
    check("ign_busy", {7'd0, busy}, 8'd0);
    strobe(8'h56);
    expect_frame("q_ver", 1'b0, 3, 8'h50);
    expect_frame("q_ping", 1'b1, -1, 8'h00);
    check("q_end_valid", {7'd0, tx_valid}, 8'd0);
    check("q_dropped", {7'd0, req_dropped}, 8'd0);

    // Overflow: three queries while stalled -> two frames, sticky drop flag.
    tx_ready = 1'b0;
    strobe(8'h56);
    strobe(8'h56);
    strobe(8'h56);
    check("ovf_dropped", {7'd0, req_dropped}, 8'd1);
    check("ovf_busy", {7'd0, busy}, 8'd1);
    check("ovf_hold", tx_data, 8'hA5);
    tx_ready = 1'b1;
    expect_frame("ovf_ver1", 1'b0, -1, 8'h00);
    expect_frame("ovf_ver2", 1'b0, -1, 8'h00);
    check("ovf_end_valid", {7'd0, tx_valid}, 8'd0);
    check("ovf_dropped_sticky", {7'd0, req_dropped}, 8'd1);

    rst_n = 1'b0; tick();
    check("rst2_dropped", {7'd0, req_dropped}, 8'd0);
    rst_n = 1'b1; tick();

    // Ping strobed on the version frame's checksum handshake.
    strobe(8'h56);
    expect_frame("col_ver", 1'b0, 13, 8'h50);
    expect_frame("col_ping", 1'b1, -1, 8'h00);
    check("col_end_valid", {7'd0, tx_valid}, 8'd0);
    check("col_dropped", {7'd0, req_dropped}, 8'd0);

    // Reset at byte 6 aborts the frame; a fresh query then completes.
    strobe(8'h56);
    for (int i = 0; i < 6; i++) tick();
    check("mid_byte6", tx_data, exp_ver[6]);
    rst_n = 1'b0; tick();
    check("mid_rst_valid", {7'd0, tx_valid}, 8'd0);
    check("mid_rst_busy", {7'd0, busy}, 8'd0);
    check("mid_rst_data", tx_data, 8'h00);
    rst_n = 1'b1; tick();
    check("mid_idle_valid", {7'd0, tx_valid}, 8'd0);
    strobe(8'h56);
    expect_frame("post_ver", 1'b0, -1, 8'h00);
    check("post_end_valid", {7'd0, tx_valid}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
